// File: rtl/sysbus_mem_responder.sv
// Memory responder for the system bus: accepts line reads and writes from the
// cache and serves them from an internal word array with programmable read latency.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4,
  parameter int BEATS          = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bus_reqcyc,
  output logic                          bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0]     bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]      bus_reqtag,
  output logic                          bus_respcyc,
  input  logic                          bus_respack,
  output logic [BUS_DATA_WIDTH-1:0]     bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]      bus_resptag,
  output logic                          busy,
  input  logic                          init_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  init_addr,
  input  logic [BUS_DATA_WIDTH-1:0]     init_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BEATS);
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK   = 3'd1,
    S_WDATA = 3'd2,
    S_RLAT  = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                       is_wr_q, is_wr_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [LW-1:0]              lat_q, lat_d;
  logic                       reqack_q, reqack_d;
  logic                       respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0]  resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]   resptag_q, resptag_d;
  logic                       busy_q, busy_d;

  logic [BUS_DATA_WIDTH-1:0]  mem_q [MEM_WORDS];

  logic [BW-1:0]              rd_beat_s;
  logic [AW-1:0]              rd_idx_s;
  logic [BUS_DATA_WIDTH-1:0]  rd_data_s;
  logic [AW-1:0]              wr_idx_s;
  logic                       wr_en_s;

  // Read-side word fetch; a preload landing on the fetched word this cycle is forwarded.
  always_comb begin
    rd_beat_s = beat_q;
    if (state_q == S_RDATA) begin
      rd_beat_s = beat_q + BW'(1);
    end else begin
      rd_beat_s = beat_q;
    end
    rd_idx_s = base_q + AW'(rd_beat_s);
    if (init_we && (init_addr == rd_idx_s)) begin
      rd_data_s = init_data;
    end else begin
      rd_data_s = mem_q[rd_idx_s];
    end
  end

  assign wr_idx_s = base_q + AW'(beat_q);

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    tag_d     = tag_q;
    is_wr_d   = is_wr_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    reqack_d  = 1'b0;
    respcyc_d = 1'b0;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    wr_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus_reqcyc) begin
          state_d  = S_ACK;
          base_d   = bus_req[AW+5:6] * AW'(BEATS);
          tag_d    = bus_reqtag;
          is_wr_d  = bus_reqtag[BUS_TAG_WIDTH-1];
          reqack_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        beat_d = '0;
        lat_d  = '0;
        if (is_wr_q) begin
          state_d = S_WDATA;
        end else begin
          state_d = S_RLAT;
        end
      end
      S_WDATA: begin
        if (bus_reqcyc) begin
          wr_en_s = 1'b1;
          if (beat_q == BW'(BEATS - 1)) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RLAT: begin
        if (lat_q == LW'(READ_LATENCY - 1)) begin
          state_d   = S_RDATA;
          beat_d    = '0;
          respcyc_d = 1'b1;
          resp_d    = rd_data_s;
          resptag_d = tag_q;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_RDATA: begin
        respcyc_d = 1'b1;
        if (bus_respack) begin
          if (beat_q == BW'(BEATS - 1)) begin
            state_d   = S_IDLE;
            respcyc_d = 1'b0;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + BW'(1);
            resp_d = rd_data_s;
          end
        end else begin
          respcyc_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; the array is deliberately outside reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      tag_q     <= '0;
      is_wr_q   <= 1'b0;
      beat_q    <= '0;
      lat_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      tag_q     <= tag_d;
      is_wr_q   <= is_wr_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
      busy_q    <= busy_d;
    end
  end

  // Word array: the bus write is applied last so it beats a same-word preload.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_addr] <= init_data;
    end
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= bus_req;
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;
  assign busy        = busy_q;

endmodule
